// File: rtl/osc_net_pkg.sv
// Shared types, default sizes and helpers for the spiking-oscillator scheduler.
package osc_net_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REFRACT = 2'd2
  } state_e;

  localparam int N_NEURONS_DEF = 4;
  localparam int IDX_W_DEF     = $clog2(N_NEURONS_DEF);

  // A zero threshold would make a neuron fire without integrating; clamp to 1.
  function automatic logic [7:0] thr_eff_f(input logic [7:0] thr);
    return (thr == 8'd0) ? 8'd1 : thr;
  endfunction

endpackage

// File: rtl/osc_network_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [2*N-1:0] rot;
  logic [IDX_W:0] sum;
  logic           found;

  always_comb begin
    // Rotating the doubled vector puts the pointer position at bit 0.
    rot       = {req, req} >> ptr;
    any       = |req;
    grant_idx = '0;
    sum       = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
        grant_idx = sum[IDX_W-1:0];
      end
    end
    grant = any ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

endmodule

// File: rtl/osc_network_ctrl.sv
// Oscillator network scheduler: prescaled integrate counters, round-robin spike
// arbitration, then global inhibition for a refractory window.
module osc_network_ctrl
  import osc_net_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int CNT_W     = 3,
  parameter int REF_W     = 3,
  parameter int PRE_W     = 8,
  localparam int IDX_W    = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [PRE_W-1:0]     prescale,
  input  logic [CNT_W-1:0]     threshold,
  input  logic [REF_W-1:0]     refract,
  input  logic [N_NEURONS-1:0] drive,
  output logic [N_NEURONS-1:0] spike,
  output logic [IDX_W-1:0]     winner,
  output logic [N_NEURONS-1:0] inhibit,
  output logic                 busy
);

  state_e                          state_q, state_d;
  logic [N_NEURONS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [IDX_W-1:0]                winner_q, winner_d;
  logic [PRE_W-1:0]                pcnt_q, pcnt_d;
  logic [REF_W-1:0]                rcnt_q, rcnt_d;
  logic [N_NEURONS-1:0]            spike_q, spike_d;
  logic [N_NEURONS-1:0]            inhibit_q, inhibit_d;

  logic [CNT_W-1:0]     thr_eff;
  logic [N_NEURONS-1:0] req, grant, win_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_req, tick, busy_int;

  assign thr_eff  = CNT_W'(thr_eff_f(8'(threshold)));
  assign busy_int = (state_q != ST_IDLE);
  assign tick     = busy_int && (pcnt_q == prescale);
  assign win_oh   = {{(N_NEURONS-1){1'b0}}, 1'b1} << winner_q;

  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_req
    assign req[gi] = (state_q == ST_RUN) && drive[gi] && (cnt_q[gi] == thr_eff);
  end

  rr_arbiter #(.N(N_NEURONS), .IDX_W(IDX_W)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    rcnt_d    = rcnt_q;
    spike_d   = '0;
    inhibit_d = '0;
    // Wrap-on-tick means a pcnt stranded above a lowered prescale runs round the full range.
    pcnt_d    = tick ? '0 : pcnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        pcnt_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        for (int i = 0; i < N_NEURONS; i++) begin
          if (tick && drive[i] && (cnt_q[i] < thr_eff)) cnt_d[i] = cnt_q[i] + 1'b1;
        end
        if (any_req) begin
          cnt_d    = '0;
          spike_d  = grant;
          winner_d = grant_idx;
          ptr_d    = (grant_idx == IDX_W'(N_NEURONS - 1)) ? '0 : grant_idx + 1'b1;
          if (refract != '0) begin
            state_d   = ST_REFRACT;
            rcnt_d    = refract;
            inhibit_d = ~grant;
          end
        end
      end
      ST_REFRACT: begin
        cnt_d     = '0;
        inhibit_d = ~win_oh;
        if (tick) begin
          if (rcnt_q == REF_W'(1)) begin
            state_d   = ST_RUN;
            rcnt_d    = '0;
            inhibit_d = '0;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!en) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      ptr_d     = '0;
      pcnt_d    = '0;
      rcnt_d    = '0;
      spike_d   = '0;
      inhibit_d = '0;
      winner_d  = winner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      winner_q  <= '0;
      pcnt_q    <= '0;
      rcnt_q    <= '0;
      spike_q   <= '0;
      inhibit_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      pcnt_q    <= pcnt_d;
      rcnt_q    <= rcnt_d;
      spike_q   <= spike_d;
      inhibit_q <= inhibit_d;
    end
  end

  assign spike   = spike_q;
  assign winner  = winner_q;
  assign inhibit = inhibit_q;
  assign busy    = busy_int;

endmodule

// File: tb/tb_osc_network_ctrl.sv
// Directed, table-driven bench for osc_network_ctrl (N=4, CNT_W=3, REF_W=3, PRE_W=8).
module tb_osc_network_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] prescale;
  logic [2:0] threshold;
  logic [2:0] refract;
  logic [3:0] drive;
  logic [3:0] spike;
  logic [1:0] winner;
  logic [3:0] inhibit;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  osc_network_ctrl #(.N_NEURONS(4), .CNT_W(3), .REF_W(3), .PRE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .prescale  (prescale),
    .threshold (threshold),
    .refract   (refract),
    .drive     (drive),
    .spike     (spike),
    .winner    (winner),
    .inhibit   (inhibit),
    .busy      (busy)
  );

  typedef struct {
    string      name;
    logic       en;
    logic [7:0] pre;
    logic [2:0] thr;
    logic [2:0] rfr;
    logic [3:0] drv;
    int         ncyc;
    logic [3:0] spike;
    logic [1:0] win;
    logic [3:0] inh;
    logic       busy;
  } vec_t;

  vec_t       vecs[$];
  logic       c_en;
  logic [7:0] c_pre;
  logic [2:0] c_thr;
  logic [2:0] c_rfr;
  logic [3:0] c_drv;

  task automatic cfg(input logic e, input logic [7:0] p, input logic [2:0] t,
                     input logic [2:0] r, input logic [3:0] d);
    c_en = e; c_pre = p; c_thr = t; c_rfr = r; c_drv = d;
  endtask

  task automatic expv(input string nm, input int n, input logic [3:0] sp,
                      input logic [1:0] w, input logic [3:0] ih, input logic b);
    vec_t v;
    v.name = nm; v.en = c_en; v.pre = c_pre; v.thr = c_thr; v.rfr = c_rfr; v.drv = c_drv;
    v.ncyc = n; v.spike = sp; v.win = w; v.inh = ih; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic check_all(input string nm, input logic [3:0] sp, input logic [1:0] w,
                           input logic [3:0] ih, input logic b);
    check({nm, ".spike"},   32'(spike),   32'(sp));
    check({nm, ".winner"},  32'(winner),  32'(w));
    check({nm, ".inhibit"}, 32'(inhibit), 32'(ih));
    check({nm, ".busy"},    32'(busy),    32'(b));
    $display("%-14s spike=%b winner=%0d inhibit=%b busy=%b", nm, spike, winner, inhibit, busy);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Single neuron, thr=4, refract=2: spikes at E5, E12; inhibit for two cycles each.
    cfg(1, 8'd0, 3'd4, 3'd2, 4'b0001);
    expv("sn_e0", 1, 4'b0000, 0, 4'b0000, 1);
    expv("sn_e4", 4, 4'b0000, 0, 4'b0000, 1);
    expv("sn_e5", 1, 4'b0001, 0, 4'b1110, 1);
    expv("sn_e6", 1, 4'b0000, 0, 4'b1110, 1);
    expv("sn_e7", 1, 4'b0000, 0, 4'b0000, 1);
    expv("sn_e11", 4, 4'b0000, 0, 4'b0000, 1);
    expv("sn_e12", 1, 4'b0001, 0, 4'b1110, 1);
    // Abort during REFRACT.
    cfg(0, 8'd0, 3'd4, 3'd2, 4'b0001);
    expv("sn_abort", 1, 4'b0000, 0, 4'b0000, 0);
    // Round-robin, thr=3, no refractory: 4-cycle spacing.
    cfg(1, 8'd0, 3'd3, 3'd0, 4'b1111);
    expv("rr_e0", 1, 4'b0000, 0, 4'b0000, 1);
    expv("rr_e3", 3, 4'b0000, 0, 4'b0000, 1);
    expv("rr_e4", 1, 4'b0001, 0, 4'b0000, 1);
    expv("rr_e7", 3, 4'b0000, 0, 4'b0000, 1);
    expv("rr_e8", 1, 4'b0010, 1, 4'b0000, 1);
    expv("rr_e12", 4, 4'b0100, 2, 4'b0000, 1);
    expv("rr_e16", 4, 4'b1000, 3, 4'b0000, 1);
    expv("rr_e20", 4, 4'b0001, 0, 4'b0000, 1);
    expv("rr_e24", 4, 4'b0010, 1, 4'b0000, 1);
    cfg(0, 8'd0, 3'd3, 3'd0, 4'b1111);
    expv("rr_off", 1, 4'b0000, 1, 4'b0000, 0);
    // Re-enable: pointer restarted at 0, so neuron 0 wins first again.
    cfg(1, 8'd0, 3'd3, 3'd0, 4'b1111);
    expv("rr2_e0", 1, 4'b0000, 1, 4'b0000, 1);
    expv("rr2_e4", 4, 4'b0001, 0, 4'b0000, 1);
    cfg(0, 8'd0, 3'd3, 3'd0, 4'b1111);
    expv("rr2_off", 1, 4'b0000, 0, 4'b0000, 0);
    // Prescaler 2, thr=2, refract=1: spikes at E7 and E16.
    cfg(1, 8'd2, 3'd2, 3'd1, 4'b0100);
    expv("ps_e0", 1, 4'b0000, 0, 4'b0000, 1);
    expv("ps_e6", 6, 4'b0000, 0, 4'b0000, 1);
    expv("ps_e7", 1, 4'b0100, 2, 4'b1011, 1);
    expv("ps_e8", 1, 4'b0000, 2, 4'b1011, 1);
    expv("ps_e9", 1, 4'b0000, 2, 4'b0000, 1);
    expv("ps_e15", 6, 4'b0000, 2, 4'b0000, 1);
    expv("ps_e16", 1, 4'b0100, 2, 4'b1011, 1);
    cfg(0, 8'd2, 3'd2, 3'd1, 4'b0100);
    expv("ps_off", 1, 4'b0000, 2, 4'b0000, 0);
    // Threshold 0 behaves as 1: spike at E2, then every 2 cycles.
    cfg(1, 8'd0, 3'd0, 3'd0, 4'b0010);
    expv("t0_e0", 1, 4'b0000, 2, 4'b0000, 1);
    expv("t0_e1", 1, 4'b0000, 2, 4'b0000, 1);
    expv("t0_e2", 1, 4'b0010, 1, 4'b0000, 1);
    expv("t0_e3", 1, 4'b0000, 1, 4'b0000, 1);
    expv("t0_e4", 1, 4'b0010, 1, 4'b0000, 1);
    cfg(0, 8'd0, 3'd0, 3'd0, 4'b0010);
    expv("t0_off", 1, 4'b0000, 1, 4'b0000, 0);

    rst_n = 1'b0; en = 1'b0; prescale = '0; threshold = '0; refract = '0; drive = '0;
    step(3);
    check_all("reset", 4'b0000, 0, 4'b0000, 0);
    rst_n = 1'b1;
    step(1);
    check_all("idle", 4'b0000, 0, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; prescale = vecs[i].pre; threshold = vecs[i].thr;
      refract = vecs[i].rfr; drive = vecs[i].drv;
      step(vecs[i].ncyc);
      check_all(vecs[i].name, vecs[i].spike, vecs[i].win, vecs[i].inh, vecs[i].busy);
    end

    // Drive withdrawal: neuron 2 saturates at E3, drive dropped for three edges.
    en = 1'b1; prescale = 8'd0; threshold = 3'd3; refract = 3'd0; drive = 4'b0100;
    step(4);
    check_all("wd_e3", 4'b0000, 1, 4'b0000, 1);
    drive = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_all($sformatf("wd_drop%0d", i), 4'b0000, 1, 4'b0000, 1);
    end
    drive = 4'b0100;
    step(1);
    check_all("wd_restore", 4'b0100, 2, 4'b0000, 1);

    // Asynchronous reset mid-RUN clears everything without waiting for an edge.
    rst_n = 1'b0;
    #2;
    check_all("async_rst", 4'b0000, 0, 4'b0000, 0);
    rst_n = 1'b1; en = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osc_network_ctrl.md
# osc_network_ctrl

Scheduler for a small network of spiking oscillator neurons. It owns one integrate counter per neuron and advances them on a shared prescaled tick. It arbitrates round-robin among neurons that reach threshold, so at most one spike fires per arbitration. After each spike it applies global mutual inhibition and a refractory window. It sits between the top-level configuration inputs and the per-neuron spike and inhibit wires.

## Interface
- N_NEURONS, 4: number of neurons scheduled; 2..8.
- CNT_W, 3: integrate counter and threshold width.
- REF_W, 3: refractory length width, in ticks.
- PRE_W, 8: prescaler width.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  network enable; low forces IDLE.
- prescale  in  PRE_W  tick period minus 1, in clk cycles.
- threshold  in  CNT_W  spike threshold; 0 treated as 1.
- refract  in  REF_W  refractory length in ticks; 0 means none.
- drive  in  N_NEURONS  per-neuron excitation enable.
- spike  out  N_NEURONS  one-hot spike pulse, 1 cycle, registered.
- winner  out  $clog2(N_NEURONS)  index of last spiking neuron, held.
- inhibit  out  N_NEURONS  high for every neuron except winner during REFRACT.
- busy  out  1  state != IDLE.

## Operation
- Reset values: all outputs 0; state IDLE; all counts 0; rr pointer 0; prescaler 0; refractory counter 0.
- States:
  - IDLE: en low.
  - RUN: integrating and arbitrating.
  - REFRACT: counts held at 0, decrementing the refractory counter.
- IDLE -> RUN on en sampled high; prescaler cleared on entry.
- Any state -> IDLE when en is low at a clock edge. Effects:
  - counts, pointer and prescaler cleared;
  - spike and inhibit go 0;
  - winner holds.
- Prescaler counts 0..prescale when busy.
  - tick = (pcnt == prescale); pcnt then wraps to 0.
  - A change to prescale takes effect on the fly, compared against the live pcnt.
  - If pcnt > new prescale, pcnt wraps through its full range.
- RUN, on tick: cnt[i] increments when drive[i] and cnt[i] < thr_eff, where thr_eff = max(threshold, 1); it saturates at thr_eff.
- Request vector: req[i] = (cnt[i] == thr_eff) && drive[i]. Dropping drive[i] withdraws the request but keeps the count.
- RUN with req != 0: the arbiter grants the first requester at or after the pointer, wrapping. At the next edge:
  - spike = onehot(g), winner = g;
  - all counts cleared; any simultaneous tick increment is discarded;
  - pointer = (g+1) mod N_NEURONS;
  - if refract == 0, stay in RUN;
  - otherwise state = REFRACT and rcnt = refract.
- REFRACT:
  - counts stay 0 and no requests are possible;
  - inhibit = ~onehot(winner);
  - on tick, if rcnt == 1 go to RUN, else rcnt decrements.
- spike is 0 in every cycle other than the grant-following cycle.

## Timing
- Grant latency: request visible combinationally in cycle k; spike registered high in cycle k+1.
- With prescale = 0, drive[i] = 1, no competition, en sampled at edge E0:
  - first spike registered at E(thr_eff + 1);
  - spike period = thr_eff + refract + 1 cycles when refract > 0;
  - spike period = thr_eff + 1 cycles when refract = 0.
- inhibit asserts with spike in the same cycle. It deasserts at the edge that enters RUN.
- rst_n low mid-operation: all state clears immediately. en low: clears at the next edge.

## Structure
- Package osc_net_pkg holds:
  - state enum (IDLE, RUN, REFRACT);
  - width-derivation localparams ($clog2(N_NEURONS));
  - the thr_eff helper function.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs req[N], ptr;
  - outputs grant one-hot, grant_idx, any;
  - purely combinational, double-vector priority rotate.
- The FSM, prescaler, counter array and output registers live in osc_network_ctrl.

## Test plan
- Single neuron. Stimulus: N=4, prescale=0, threshold=4, refract=2, drive=0001, en raised. Required: spike=0001 at E5, then every 7 cycles; inhibit=1110 for the 2 cycles after each spike; winner=0.
- Round-robin. Stimulus: drive=1111, threshold=3, refract=0, prescale=0. Required: spike sequence 0001, 0010, 0100, 1000, 0001 at 4-cycle spacing.
- Prescaler. Stimulus: prescale=2, threshold=2, refract=1, drive=0100. Required: spike=0100 every 9 cycles; counts change only on every third cycle.
- threshold=0 with drive=0010. Required: behaves identically to threshold=1; spike=0010 two cycles after en is sampled.
- Mid-operation abort:
  - en dropped during REFRACT: next cycle busy=0, inhibit=0000, spike=0000.
  - Re-enable: pointer has restarted at 0.
  - rst_n pulse during RUN: all outputs 0 immediately.
- Drive withdrawal. Stimulus: neuron 2 saturated, drive[2] dropped for 3 cycles, then restored. Required: no spike while dropped; spike=0100 one cycle after restore.
